// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle RISC-V M-extension execution unit. Accepts ALU control codes
//   11..18 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) through a
//   start/busy/done handshake. Multiply is a single registered step. Divide is
//   a radix-2 restoring divider. Divide-by-zero and signed overflow are
//   resolved at accept time.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   start    in   request strobe, honoured only in IDLE
//   flush    in   pipeline kill; aborts MUL/DIV/FIX, blocks accept in IDLE
//   alu_ctl  in   5-bit operation code (11..18)
//   op_a     in   rs1 operand / dividend
//   op_b     in   rs2 operand / divisor
//   busy     out  operation in flight (MUL, DIV, FIX)
//   done     out  one-cycle result-valid pulse (DONE)
//   result   out  result, held until the next completed operation
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN      = 32,
   parameter int DIV_CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [4:0]      alu_ctl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

   logic [2:0]           r_state;
   logic [4:0]           r_op;
   logic [XLEN-1:0]      r_a;
   logic [XLEN-1:0]      r_b;
   logic [XLEN-1:0]      r_rem;
   logic [XLEN-1:0]      r_quo;
   logic [XLEN-1:0]      r_div;
   logic [DIV_CNT_W-1:0] r_cnt;
   logic                 r_qneg;
   logic                 r_rneg;
   logic [XLEN-1:0]      r_result;

   // ---------------- accept-time decode (uses live inputs) ----------------
   logic            w_valid_op;
   logic            w_accept;
   logic            w_in_div;
   logic            w_in_signed;
   logic            w_in_rem;
   logic            w_div0;
   logic            w_ovf;
   logic [XLEN-1:0] w_special;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;

   assign w_valid_op  = (alu_ctl >= 5'd11) && (alu_ctl <= 5'd18);
   assign w_accept    = (r_state == S_IDLE) && start && !flush && w_valid_op;
   assign w_in_div    = (alu_ctl >= 5'd15);
   assign w_in_signed = (alu_ctl == 5'd15) || (alu_ctl == 5'd17);
   assign w_in_rem    = (alu_ctl == 5'd17) || (alu_ctl == 5'd18);
   assign w_div0      = (op_b == '0);
   assign w_ovf       = w_in_signed && (op_a == MIN_NEG) && (op_b == ALL_ONE);
   // Divide-by-zero has precedence; overflow is only meaningful when op_b!=0.
   assign w_special   = w_div0 ? (w_in_rem ? op_a : ALL_ONE)
                               : (w_in_rem ? '0 : MIN_NEG);
   assign w_a_neg     = w_in_signed && op_a[XLEN-1];
   assign w_b_neg     = w_in_signed && op_b[XLEN-1];
   assign w_a_mag     = w_a_neg ? (~op_a + 1'b1) : op_a;
   assign w_b_mag     = w_b_neg ? (~op_b + 1'b1) : op_b;

   // ---------------- multiply datapath ----------------
   logic              w_mul_a_sx;
   logic              w_mul_b_sx;
   logic [2*XLEN-1:0] w_mul_a_ext;
   logic [2*XLEN-1:0] w_mul_b_ext;
   logic [2*XLEN-1:0] w_prod;

   assign w_mul_a_sx  = (r_op == 5'd11) || (r_op == 5'd12) || (r_op == 5'd13);
   assign w_mul_b_sx  = (r_op == 5'd11) || (r_op == 5'd12);
   assign w_mul_a_ext = {{XLEN{w_mul_a_sx & r_a[XLEN-1]}}, r_a};
   assign w_mul_b_ext = {{XLEN{w_mul_b_sx & r_b[XLEN-1]}}, r_b};
   // The low 2*XLEN bits of the sign-extended product are exact for every
   // signed/unsigned operand mix.
   assign w_prod      = w_mul_a_ext * w_mul_b_ext;

   // ---------------- restoring divide step ----------------
   logic [XLEN:0]   w_rem_sh;
   logic            w_ge;
   logic [XLEN-1:0] w_rem_sub;
   logic [XLEN-1:0] w_q_fix;
   logic [XLEN-1:0] w_r_fix;
   logic            w_op_rem;

   // Partial remainder shifted by one needs XLEN+1 bits to compare safely.
   assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_div});
   // When w_ge holds the true difference is < r_div, so XLEN bits suffice.
   assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_div;
   assign w_q_fix   = r_qneg ? (~r_quo + 1'b1) : r_quo;
   assign w_r_fix   = r_rneg ? (~r_rem + 1'b1) : r_rem;
   assign w_op_rem  = (r_op == 5'd17) || (r_op == 5'd18);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op <= alu_ctl;
                  r_a  <= op_a;
                  r_b  <= op_b;
                  if (!w_in_div) begin
                     r_state <= S_MUL;
                  end else if (w_div0 || w_ovf) begin
                     r_result <= w_special;
                     r_state  <= S_DONE;
                  end else begin
                     r_quo   <= w_a_mag;
                     r_rem   <= '0;
                     r_div   <= w_b_mag;
                     r_qneg  <= w_a_neg ^ w_b_neg;
                     r_rneg  <= w_a_neg;
                     r_cnt   <= DIV_CNT_W'(XLEN - 1);
                     r_state <= S_DIV;
                  end
               end
            end
            S_MUL: begin
               if (flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_result <= (r_op == 5'd11) ? w_prod[XLEN-1:0]
                                              : w_prod[2*XLEN-1:XLEN];
                  r_state  <= S_DONE;
               end
            end
            S_DIV: begin
               if (flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
                  r_quo <= {r_quo[XLEN-2:0], w_ge};
                  if (r_cnt == '0) begin
                     r_state <= S_FIX;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            S_FIX: begin
               if (flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_result <= w_op_rem ? w_r_fix : w_q_fix;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
   assign done   = (r_state == S_DONE);
   assign result = r_result;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle M-extension execution unit downstream of the ALU control decoder.
- Consumes the 5-bit ALU control codes 11–18 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) plus both operands.
- Returns a 32-bit result through a start/busy/done handshake; the pipeline stalls on busy.
- Multiply uses a registered single-step datapath; divide is an iterative radix-2 restoring divider with the RISC-V special cases resolved up front.

Parameters:
XLEN, 32, operand/result width
DIV_CNT_W, 6, width of the iteration counter (must hold XLEN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request strobe, sampled only in IDLE
flush  input  1  abort current operation (pipeline kill)
alu_ctl  input  5  operation code: 11 mul, 12 mulh, 13 mulhsu, 14 mulhu, 15 div, 16 divu, 17 rem, 18 remu
op_a  input  XLEN  rs1 operand / dividend
op_b  input  XLEN  rs2 operand / divisor
busy  output  1  operation in flight; upstream must hold the instruction
done  output  1  one-cycle pulse: result valid
result  output  XLEN  operation result, held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE, busy 0, done 0, result 0, all internal registers 0.
- Reset mid-operation discards the operation with no done pulse.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept rule: start=1 in IDLE with alu_ctl in 11..18 latches alu_ctl, op_a and op_b (cycle T).
  - start with any other code is ignored.
  - start while not IDLE is ignored; no queueing.
- busy: 1 in MUL, DIV and FIX; 0 in IDLE and DONE.
- done: 1 only in DONE, which lasts one cycle and then returns to IDLE.
- Back-to-back: start may be accepted in the cycle after DONE (IDLE again).
- Multiply (11–14):
  - IDLE→MUL at T+1. MUL forms the 2*XLEN product with operand sign-extension per op.
    - mul: signed×signed.
    - mulh: signed×signed.
    - mulhsu: signed op_a × unsigned op_b.
    - mulhu: unsigned×unsigned.
  - result = low XLEN bits for mul, high XLEN bits otherwise.
  - DONE at T+2. Fixed latency 2.
- Divide, special cases (checked at T using the latched operands):
  - op_b==0: div/divu quotient = all ones; rem/remu = op_a.
  - Signed overflow (op_a==0x80000000, op_b==0xFFFFFFFF) for div: result 0x80000000; for rem: result 0.
  - Both cases go IDLE→DONE directly; done at T+1.
- Divide, normal path:
  - Signed ops take magnitudes and record the quotient sign (a^b) and remainder sign (a).
  - DIV runs exactly XLEN iterations, T+1..T+XLEN. Each iteration shifts {rem,quo} left one bit, subtracts the divisor, and restores when the difference is negative.
  - FIX at T+XLEN+1 applies the sign correction and selects quotient or remainder. The remainder takes the dividend's sign.
  - DONE at T+XLEN+2.
  - Iteration counter counts XLEN-1 down to 0; no wrap beyond.
- flush:
  - In MUL, DIV or FIX: next state IDLE; no done; result unchanged (holds the previous value).
  - In DONE: the done pulse still occurs.
  - flush takes priority over a start in the same cycle.
  - In IDLE, flush blocks acceptance in that cycle.
- Simultaneous reset and flush/start: reset wins.
- Operands are captured at accept; changes on op_a, op_b or alu_ctl while busy have no effect.

Test Plan:
- Reset held 2 cycles, then start mul with op_a=7, op_b=6 → busy=1 at T+1; done=1 and result=42 at T+2; busy=0 at T+2.
- mulh 0x80000000×0x80000000 → 0x40000000; mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; mulhsu 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- div −20÷3 → 0xFFFFFFFA (−6), done at T+34; rem −20÷3 → 0xFFFFFFFE (−2); divu 100÷7 → 14; remu 100÷7 → 2.
- Special cases:
  - div 5÷0 → 0xFFFFFFFF at T+1.
  - rem 5÷0 → 5.
  - div 0x80000000÷0xFFFFFFFF → 0x80000000 at T+1.
  - rem of the same → 0.
- divu accepted, flush asserted at T+10 → IDLE at T+11, no done pulse, result keeps the prior value. A start during busy is ignored. A new start at T+11 completes normally.
- reset asserted mid-DIV at T+5 → busy=0, result=0 at T+6. A start with alu_ctl=2 (add) in IDLE → no busy, no done.
